// File: rtl/debug_pkg.sv
// Shared encodings and constants for the post-halt debug dump path.
// The frame-length constant is shared with the host-side capture script.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT_RD,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_TX,
    ST_NEXT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_PC,
    PH_REG,
    PH_MEM
  } phase_t;

  localparam int NB_BYTE_CNT = 2;
  localparam int FRAME_BYTES = 260;

  function automatic int frame_len(input int n_reg, input int n_mem);
    return 4 * (1 + n_reg + n_mem);
  endfunction

endpackage

// File: rtl/debug_word_serializer.sv
// Holds one dump word and hands it to tx_uart MSB byte first.
// Flags word_done on the done tick that completes the last byte.
module debug_word_serializer
  import debug_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic [NB_DATA-1:0] load_data_i,
  input  logic               send_i,
  input  logic               wait_tx_i,
  input  logic               tx_done_tick_i,
  output logic [NB_BYTE-1:0] tx_data_o,
  output logic               tx_start_o,
  output logic               byte_done_o,
  output logic               word_done_o
);

  localparam logic [NB_BYTE_CNT-1:0] LAST_BYTE = NB_BYTE_CNT'(NB_DATA / NB_BYTE - 1);

  logic [NB_DATA-1:0]     shift_q;
  logic [NB_BYTE_CNT-1:0] byte_cnt_q;

  // Done ticks only count while a frame is actually outstanding.
  assign byte_done_o = wait_tx_i && tx_done_tick_i;
  assign word_done_o = byte_done_o && (byte_cnt_q == LAST_BYTE);
  assign tx_data_o   = shift_q[NB_DATA-1 -: NB_BYTE];
  assign tx_start_o  = send_i;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else if (load_i) begin
      shift_q    <= load_data_i;
      byte_cnt_q <= '0;
    end else if (byte_done_o) begin
      shift_q    <= {shift_q[NB_DATA-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
      byte_cnt_q <= byte_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/debug_dump_unit.sv
// Streams PC, register file and the first data-memory words to tx_uart
// after a halt; owns the phase/word sequencing and the debug read ports.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start_i; PC word latched on start
// ADDR    | drive register/memory read address from word_cnt
// WAIT_RD | hold address while the synchronous read completes
// LOAD    | capture read data into the serializer
// SEND    | one-cycle tx_start pulse for the current byte
// WAIT_TX | wait for tx_done_tick, then next byte or NEXT
// NEXT    | advance word_cnt / phase, or finish
// DONE    | one-cycle done pulse
module debug_dump_unit
  import debug_pkg::*;
#(
  parameter int NB_DATA     = 32,
  parameter int N_REGISTER  = 32,
  parameter int N_MEM_WORDS = 32,
  parameter int NB_PC       = 7,
  parameter int NB_MEM_ADDR = 7,
  parameter int NB_BYTE     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [NB_PC-1:0]       pc_i,
  output logic [4:0]             reg_addr_o,
  input  logic [NB_DATA-1:0]     reg_data_i,
  output logic [NB_MEM_ADDR-1:0] mem_addr_o,
  input  logic [NB_DATA-1:0]     mem_data_i,
  output logic [NB_BYTE-1:0]     tx_data_o,
  output logic                   tx_start_o,
  input  logic                   tx_done_tick_i,
  output logic                   busy_o,
  output logic                   done_o
);

  // word_cnt must address every register and, shifted by two, every memory word
  localparam int NB_WC = (NB_MEM_ADDR - 2 > 5) ? NB_MEM_ADDR - 2 : 5;
  localparam logic [NB_WC-1:0] LAST_REG = NB_WC'(N_REGISTER - 1);
  localparam logic [NB_WC-1:0] LAST_MEM = NB_WC'(N_MEM_WORDS - 1);

  state_t             state_q, state_d;
  phase_t             phase_q, phase_d;
  logic [NB_WC-1:0]   word_cnt_q, word_cnt_d;

  logic               load;
  logic [NB_DATA-1:0] load_data;
  logic               byte_done;
  logic               word_done;
  logic               rd_active;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_PC;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          phase_d    = PH_PC;
          word_cnt_d = '0;
          state_d    = ST_SEND;
        end
      end
      ST_ADDR:    state_d = ST_WAIT_RD;
      ST_WAIT_RD: state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_SEND;
      ST_SEND:    state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (word_done) begin
          state_d = ST_NEXT;
        end else if (byte_done) begin
          state_d = ST_SEND;
        end
      end
      ST_NEXT: begin
        state_d = ST_ADDR;
        case (phase_q)
          PH_PC: begin
            phase_d    = PH_REG;
            word_cnt_d = '0;
          end
          PH_REG: begin
            if (word_cnt_q == LAST_REG) begin
              phase_d    = PH_MEM;
              word_cnt_d = '0;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end
          default: begin
            if (word_cnt_q == LAST_MEM) begin
              state_d = ST_DONE;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Addresses are only driven while a read is in flight, zero otherwise.
  assign rd_active  = (state_q == ST_ADDR) || (state_q == ST_WAIT_RD);
  assign reg_addr_o = (rd_active && phase_q == PH_REG) ? word_cnt_q[4:0] : '0;
  assign mem_addr_o = (rd_active && phase_q == PH_MEM) ?
                      {word_cnt_q[NB_MEM_ADDR-3:0], 2'b00} : '0;

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);

  assign load = ((state_q == ST_IDLE) && start_i) || (state_q == ST_LOAD);

  always_comb begin
    load_data = {{(NB_DATA-NB_PC){1'b0}}, pc_i};
    if (state_q == ST_LOAD) begin
      load_data = (phase_q == PH_REG) ? reg_data_i : mem_data_i;
    end
  end

  debug_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .clock          (clock),
    .reset          (reset),
    .load_i         (load),
    .load_data_i    (load_data),
    .send_i         (state_q == ST_SEND),
    .wait_tx_i      (state_q == ST_WAIT_TX),
    .tx_done_tick_i (tx_done_tick_i),
    .tx_data_o      (tx_data_o),
    .tx_start_o     (tx_start_o),
    .byte_done_o    (byte_done),
    .word_done_o    (word_done)
  );

endmodule

// File: tb/tb_debug_dump_unit.sv
// Directed bench for debug_dump_unit: register/memory read models and a
// tx_uart stand-in driven cycle by cycle from the main initial block.
module tb_debug_dump_unit;
  import debug_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_i;
  logic [6:0]  pc_i;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_i;
  logic [6:0]  mem_addr_o;
  logic [31:0] mem_data_i;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        tx_done_tick_i;
  logic        busy_o;
  logic        done_o;

  always #5 clock = ~clock;

  debug_dump_unit dut (
    .clock          (clock),
    .reset          (reset),
    .start_i        (start_i),
    .pc_i           (pc_i),
    .reg_addr_o     (reg_addr_o),
    .reg_data_i     (reg_data_i),
    .mem_addr_o     (mem_addr_o),
    .mem_data_i     (mem_data_i),
    .tx_data_o      (tx_data_o),
    .tx_start_o     (tx_start_o),
    .tx_done_tick_i (tx_done_tick_i),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [32];
  logic [31:0] mem  [32];
  logic [4:0]  rd_q = '0;
  logic [4:0]  md_q = '0;

  logic [7:0] rx [300];
  int   rx_n, done_n, first_k, unstable, extra, addr5_cnt, mem7c_cnt, both_cnt, busy_at1;
  int   cd = 0;
  logic [7:0] cur_byte = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [6:0] pc);
    int w;
    logic [31:0] word;
    w = i / 4;
    if (w == 0)       word = {25'd0, pc};
    else if (w <= 32) word = 32'h1000_0000 + 32'(w - 1);
    else              word = 32'hA5A5_0000 + 32'(w - 33);
    return word[31 - 8*(i % 4) -: 8];
  endfunction

  // Caller leaves start_i set at a negedge; runs until done_o is seen.
  task automatic run_dump(input logic [6:0] pc, input bit hold, input int stall_byte,
                          input bit spurious);
    int  k;
    bit  prev5;
    rx_n = 0; done_n = 0; first_k = -1; unstable = 0; extra = 0;
    addr5_cnt = 0; mem7c_cnt = 0; both_cnt = 0; busy_at1 = 0;
    pc_i = pc;
    k = 0;
    while (done_n == 0 && k < 6000) begin
      @(negedge clock);
      k++;
      reg_data_i = regs[rd_q];
      mem_data_i = mem[md_q];
      prev5 = (rd_q == 5'd5);
      rd_q = reg_addr_o;
      md_q = mem_addr_o[6:2];
      if (k == 1) busy_at1 = int'(busy_o);
      if (reg_addr_o == 5'd5) addr5_cnt++;
      if (mem_addr_o == 7'h7C) mem7c_cnt++;
      if (reg_addr_o != 0 && mem_addr_o != 0) both_cnt++;
      if (done_o) done_n++;
      if (spurious && k == 50) start_i = 1'b1;
      else if (!hold) start_i = 1'b0;
      tx_done_tick_i = 1'b0;
      if (tx_start_o) begin
        if (cd > 0) extra++;
        else begin
          if (first_k < 0) first_k = k;
          if (rx_n < 300) rx[rx_n] = tx_data_o;
          rx_n++;
          cur_byte = tx_data_o;
          cd = (rx_n - 1 == stall_byte) ? 1005 : 5;
        end
      end else if (cd > 0) begin
        if (tx_data_o !== cur_byte) unstable++;
        cd--;
        if (cd == 0) tx_done_tick_i = 1'b1;
      end
      // the cycle after reg 5's address drops is LOAD: a tick here must be ignored
      if (spurious && prev5 && reg_addr_o != 5'd5) tx_done_tick_i = 1'b1;
    end
  endtask

  task automatic verify(input logic [6:0] pc);
    int bad;
    bad = 0;
    for (int i = 0; i < 260; i++)
      if (i >= rx_n || rx[i] !== exp_byte(i, pc)) bad++;
    check("byte_count", rx_n, FRAME_BYTES);
    check("byte_content_errors", bad, 0);
    check("done_pulses", done_n, 1);
    check("tx_data_unstable", unstable, 0);
    check("extra_tx_start", extra, 0);
    check("reg5_addr_cycles", addr5_cnt, 2);
    check("mem7c_addr_cycles", mem7c_cnt, 2);
    check("both_addr_active", both_cnt, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      regs[i] = 32'h1000_0000 + 32'(i);
      mem[i]  = 32'hA5A5_0000 + 32'(i);
    end
    reset = 1'b0; start_i = 1'b0; pc_i = '0; tx_done_tick_i = 1'b0;
    reg_data_i = '0; mem_data_i = '0;
    repeat (3) @(negedge clock);
    check("rst_tx_start", tx_start_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_tx_data", tx_data_o, 0);
    check("rst_addrs", {reg_addr_o, mem_addr_o}, 0);
    reset = 1'b1;
    @(negedge clock);

    // Start, then reset while the first SEND is active.
    pc_i = 7'h2C; start_i = 1'b1;
    @(negedge clock);
    start_i = 1'b0;
    check("pre_abort_tx_start", tx_start_o, 1);
    check("pre_abort_tx_data", tx_data_o, 8'h00);
    reset = 1'b0;
    #1;
    check("abort_tx_start", tx_start_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_outputs", {tx_data_o, done_o, reg_addr_o, mem_addr_o}, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Full dump with a mid-dump start pulse and a tick injected during LOAD.
    start_i = 1'b1;
    run_dump(7'h2C, 1'b0, -1, 1'b1);
    check("first_start_cycle", first_k, 1);
    check("busy_cycle1", busy_at1, 1);
    check("pc_byte0", rx[0], 8'h00);
    check("pc_byte3", rx[3], 8'h2C);
    check("reg5_byte3", rx[27], 8'h05);
    verify(7'h2C);
    @(negedge clock);
    check("idle_busy", busy_o, 0);
    check("idle_done", done_o, 0);
    repeat (3) @(negedge clock);
    check("no_restart", busy_o, 0);

    // Stall: byte 10 waits an extra 1000 cycles for its done tick.
    start_i = 1'b1;
    run_dump(7'h7F, 1'b0, 10, 1'b0);
    check("stall_first_start", first_k, 1);
    verify(7'h7F);
    @(negedge clock);
    check("stall_idle_busy", busy_o, 0);

    // start_i held high: second dump begins two cycles after done_o.
    start_i = 1'b1;
    run_dump(7'h15, 1'b1, -1, 1'b0);
    verify(7'h15);
    run_dump(7'h15, 1'b1, -1, 1'b0);
    start_i = 1'b0;
    check("restart_gap", first_k, 2);
    verify(7'h15);
    repeat (2) @(negedge clock);
    check("final_busy", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
